// File: rtl/dilithium_pkg.sv
// Shared constants, types and helpers for the Dilithium datapath blocks.
//   N, LOGN, ETA, Q, QW : polynomial and modulus geometry
//   coeff_t             : one canonical mod-q coefficient
//   state_e             : streaming FSM states
//   brv()               : bit reversal of a coefficient index over LOGN bits
package dilithium_pkg;

  localparam int unsigned N    = 256;
  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned ETA  = 2;
  localparam int unsigned Q    = 8380417;
  localparam int unsigned QW   = 23;

  typedef logic [QW-1:0] coeff_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  function automatic logic [LOGN-1:0] brv(input logic [LOGN-1:0] idx);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = idx[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eta_coeff_map.sv
// Combinational single-lane mapper from a packed small field (holding ETA - c)
// to the canonical mod-q coefficient c.
//   field   in  packed field value
//   coeff   out c when c >= 0, else Q + c; 0 for an illegal field
//   illegal out field exceeds 2*ETA
module eta_coeff_map
  import dilithium_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = 3
) (
  input  logic [COEFF_WIDTH-1:0] field,
  output coeff_t                 coeff,
  output logic                   illegal
);

  localparam logic [COEFF_WIDTH-1:0] FMax     = COEFF_WIDTH'(2 * ETA);
  localparam logic [COEFF_WIDTH-1:0] FEta     = COEFF_WIDTH'(ETA);
  localparam coeff_t                 EtaQ     = QW'(ETA);
  localparam coeff_t                 QPlusEta = QW'(Q + ETA);

  always_comb begin
    illegal = 1'b0;
    coeff   = '0;
    if (field > FMax) begin
      illegal = 1'b1;
    end else if (field <= FEta) begin
      coeff = EtaQ - QW'(field);
    end else begin
      // Negative c wraps to Q + c = Q + ETA - field
      coeff = QPlusEta - QW'(field);
    end
  end

endmodule

// File: rtl/eta_poly_to_modq.sv
// Streams one packed small-coefficient polynomial out as canonical mod-q
// coefficients, LANES per beat, with valid/ready backpressure.
//   clk, rst   clock, asynchronous active-high reset
//   start      one-cycle request; captures poly_pack when idle
//   poly_pack  packed fields, field i at [i*COEFF_WIDTH +: COEFF_WIDTH]
//   busy       high while streaming
//   out_valid / out_ready / out_data / out_index / out_last : output beat
//   done       one-cycle pulse after the final handshake
//   err        sticky illegal-field flag, cleared by the next accepted start
// Build option: define NTT_BITREV_EN to emit coefficients in bit-reversed
// order (out_index stays sequential).
module eta_poly_to_modq
  import dilithium_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = 3,
  parameter int unsigned LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COEFF_WIDTH*N-1:0] poly_pack,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*QW-1:0]      out_data,
  output logic [LOGN-1:0]          out_index,
  output logic                     out_last,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned Beats = N / LANES;
  localparam int unsigned KW    = $clog2(Beats);
  localparam int unsigned LW    = $clog2(LANES);

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [LANES*QW-1:0]      data_q, data_d;
  logic                     err_q, err_d;
  logic [COEFF_WIDTH*N-1:0] poly_q;

  logic                     idle, hs, last_beat, any_illegal;
  logic [COEFF_WIDTH*N-1:0] src;
  logic [KW-1:0]            beat_sel;
  logic [LANES*QW-1:0]      next_data;
  logic [LANES-1:0]         lane_illegal;

  assign idle      = (state_q == StIdle);
  assign hs        = out_valid & out_ready;
  assign last_beat = (k_q == KW'(Beats - 1));

  // The first beat is built straight from poly_pack so it can be registered
  // in the same edge that loads the shadow copy.
  assign src      = idle ? poly_pack : poly_q;
  assign beat_sel = idle ? '0 : k_q + KW'(1);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [LOGN-1:0]        seq_idx;
    logic [LOGN-1:0]        idx;
    logic [COEFF_WIDTH-1:0] field;
    coeff_t                 coeff;

    assign seq_idx = (LOGN'(beat_sel) << LW) | LOGN'(j);
`ifdef NTT_BITREV_EN
    assign idx = brv(seq_idx);
`else
    assign idx = seq_idx;
`endif
    assign field = src[idx*COEFF_WIDTH +: COEFF_WIDTH];

    eta_coeff_map #(
      .COEFF_WIDTH(COEFF_WIDTH)
    ) u_map (
      .field  (field),
      .coeff  (coeff),
      .illegal(lane_illegal[j])
    );

    assign next_data[j*QW +: QW] = coeff;
  end

  assign any_illegal = |lane_illegal;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          k_d     = '0;
          data_d  = next_data;
          err_d   = any_illegal;
        end
      end
      StStream: begin
        if (hs) begin
          // Wraps to zero after the final beat
          k_d = k_q + KW'(1);
          if (last_beat) begin
            state_d = StDone;
          end else begin
            data_d = next_data;
            err_d  = err_q | any_illegal;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      poly_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (idle && start) begin
        poly_q <= poly_pack;
      end
    end
  end

  assign busy      = (state_q == StStream);
  assign out_valid = (state_q == StStream);
  assign done      = (state_q == StDone);
  assign out_data  = data_q;
  assign out_index = LOGN'(k_q) << LW;
  assign out_last  = out_valid & last_beat;
  assign err       = err_q;

endmodule

// File: tb/tb_eta_poly_to_modq.sv
module tb_eta_poly_to_modq;
  import dilithium_pkg::*;

  localparam int unsigned CW    = 3;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = N / LANES;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [CW*N-1:0]      poly_pack = '0;
  logic                 busy, out_valid;
  logic                 out_ready = 1'b0;
  logic [LANES*QW-1:0]  out_data;
  logic [LOGN-1:0]      out_index;
  logic                 out_last, done, err;

  int tests = 0;
  int fails = 0;
  int fld[N];

  always #5 clk = ~clk;

  eta_poly_to_modq #(
    .COEFF_WIDTH(CW),
    .LANES      (LANES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .poly_pack(poly_pack),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .done     (done),
    .err      (err)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: c = ETA - f, wrapped into [0, Q); illegal fields give 0.
  function automatic int ref_coeff(input int f);
    int c;
    if (f > 2 * int'(ETA)) return 0;
    c = int'(ETA) - f;
    if (c >= 0) return c;
    return int'(Q) + c;
  endfunction

  // Which coefficient of the polynomial appears at beat b, lane j.
  function automatic int coeff_pos(input int b, input int j);
    int idx, r;
    idx = b * int'(LANES) + j;
    r   = idx;
`ifdef NTT_BITREV_EN
    r = 0;
    for (int i = 0; i < int'(LOGN); i++) begin
      if (((idx >> i) & 1) == 1) r = r | (1 << (int'(LOGN) - 1 - i));
    end
`endif
    return r;
  endfunction

  task automatic pack_fields();
    for (int i = 0; i < int'(N); i++) poly_pack[i*CW +: CW] = CW'(fld[i]);
  endtask

  task automatic fill_random_legal();
    for (int i = 0; i < int'(N); i++) fld[i] = int'($urandom_range(2 * ETA));
  endtask

  task automatic stream_poly(input string name, input int stall_pct, input int stall_beat,
                             input int restart_beat, input int rst_beat);
    int                  beat = 0;
    int                  cycles = 0;
    int                  stall_used = 0;
    bit                  exp_err = 0;
    bit                  stalled_prev = 0;
    bit                  restarted = 0;
    logic [LANES*QW-1:0] prev_data;
    logic [LOGN-1:0]     prev_index;
    logic [QW-1:0]       got, want;

    pack_fields();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (beat < int'(BEATS) && cycles < 8 * int'(BEATS)) begin
      start = 1'b0;
      if (beat == restart_beat && !restarted) begin
        restarted = 1;
        start     = 1'b1;
        for (int i = 0; i < int'(N); i++) poly_pack[i*CW +: CW] = CW'($urandom_range(7));
      end
      for (int j = 0; j < int'(LANES); j++) begin
        if (fld[coeff_pos(beat, j)] > 2 * int'(ETA)) exp_err = 1;
      end
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL %s valid/busy beat %0d: got %b/%b want 1/1", name, beat, out_valid, busy);
      end
      tests++;
      if (out_index !== LOGN'(beat * int'(LANES))) begin
        fails++;
        $display("FAIL %s out_index beat %0d: got %0d want %0d", name, beat, out_index,
                 beat * int'(LANES));
      end
      tests++;
      if (out_last !== (beat == int'(BEATS) - 1)) begin
        fails++;
        $display("FAIL %s out_last beat %0d: got %b want %b", name, beat, out_last,
                 (beat == int'(BEATS) - 1));
      end
      for (int j = 0; j < int'(LANES); j++) begin
        got  = out_data[j*QW +: QW];
        want = QW'(ref_coeff(fld[coeff_pos(beat, j)]));
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL %s lane beat %0d lane %0d: got %0d want %0d", name, beat, j, got, want);
        end
      end
      tests++;
      if (err !== exp_err) begin
        fails++;
        $display("FAIL %s err beat %0d: got %b want %b", name, beat, err, exp_err);
      end
      if (stalled_prev) begin
        tests++;
        if (out_data !== prev_data || out_index !== prev_index) begin
          fails++;
          $display("FAIL %s stall_hold beat %0d: got idx %0d want idx %0d", name, beat,
                   out_index, prev_index);
        end
      end
      if (beat == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_data !== '0 ||
            out_index !== '0) begin
          fails++;
          $display("FAIL %s async_reset: got valid %b busy %b err %b idx %0d want all 0", name,
                   out_valid, busy, err, out_index);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
          tests++;
          if (done !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s post_reset: got done %b valid %b want 0 0", name, done, out_valid);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        return;
      end
      if (beat == stall_beat && stall_used < 3) begin
        out_ready = 1'b0;
        stall_used++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      prev_data    = out_data;
      prev_index   = out_index;
      stalled_prev = !out_ready;
      @(posedge clk);
      #1;
      if (!stalled_prev) beat++;
      cycles++;
    end
    start = 1'b0;
    tests++;
    if (beat != int'(BEATS)) begin
      fails++;
      $display("FAIL %s handshakes: got %0d want %0d (cycle budget expired)", name, beat, BEATS);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b0;
      return;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle: got done %b busy %b valid %b want 1 0 0", name, done, busy,
               out_valid);
    end
    tests++;
    if (err !== exp_err) begin
      fails++;
      $display("FAIL %s err_at_done: got %b want %b", name, err, exp_err);
    end
    if (stall_pct == 0 && stall_beat < 0) begin
      tests++;
      if (cycles != int'(BEATS)) begin
        fails++;
        $display("FAIL %s latency: got %0d stream cycles want %0d", name, cycles, BEATS);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_pulse_width: got done %b busy %b want 0 0", name, done, busy);
    end
    tests++;
    if (err !== exp_err) begin
      fails++;
      $display("FAIL %s err_idle: got %b want %b", name, err, exp_err);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy %b valid %b last %b done %b want 0", busy, out_valid,
               out_last, done);
    end
    tests++;
    if (err !== 1'b0 || out_index !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got err %b idx %0d data %h want 0", err, out_index, out_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_two();
    for (int i = 0; i < int'(N); i++) fld[i] = 2;
    stream_poly("all_two", 0, -1, -1, -1);
  endtask

  task automatic test_pattern();
    for (int i = 0; i < int'(N); i++) fld[i] = (i % 4 < 2) ? (i % 4) : (i % 4) + 1;
    stream_poly("pattern", 0, -1, -1, -1);
  endtask

  task automatic test_stall();
    fill_random_legal();
    stream_poly("stall", 0, 5, -1, -1);
  endtask

  task automatic test_illegal();
    fill_random_legal();
    fld[37] = 7;
    stream_poly("illegal", 20, -1, -1, -1);
    fill_random_legal();
    stream_poly("err_clear", 0, -1, -1, -1);
  endtask

  task automatic test_reset_midstream();
    fill_random_legal();
    fld[5] = 6;
    stream_poly("reset_mid", 0, -1, -1, 10);
    fill_random_legal();
    stream_poly("after_reset", 30, -1, -1, -1);
  endtask

  task automatic test_restart_ignored();
    fill_random_legal();
    stream_poly("restart", 0, -1, 3, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        fld[i] = ($urandom_range(99) < 2) ? int'($urandom_range(5, 7))
                                          : int'($urandom_range(2 * ETA));
      end
      stream_poly("random", int'($urandom_range(50)), -1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_all_two();
    test_pattern();
    test_stall();
    test_illegal();
    test_reset_midstream();
    test_restart_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
